first_bit_restorer: RTL and testbench
=====================================

# first_bit_restorer

Inverse of `first_bit_checker`: consumes normalized fixed-point words `{shift_data, shift_info, nzero}` and right-shifts `shift_data` by `shift_info` to rebuild the original `DATA_W`-bit value. It sits on the return path of the fixed-point datapath, after any arithmetic done on normalized mantissas. It is a 3-stage pipelined barrel shifter with AXI-Stream-style backpressure and a sticky format-error counter.

## Interface
- `DATA_W`, 192, data width of the original and normalized word
- `SH_W`, `clogb2(DATA_W-1)` (8 at default), width of `shift_info`
- `ERR_W`, 16, width of the error counter
- `clk`  in  1  single clock, rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `fixp_in_stream`  stream slave  `DATA_W+SH_W+1`  tdata[0]=nzero, tdata[1+:SH_W]=shift_info, tdata[1+SH_W+:DATA_W]=shift_data
- `fixp_out_stream`  stream master  `DATA_W`  restored value
- `err_cnt`  out  `ERR_W`  count of malformed input words accepted, saturating

## Operation
- Normalized form: leading one of the original value sits at bit `DATA_W-1` of `shift_data`; `shift_info` is the left-shift count applied; `nzero=1` iff the original was nonzero.
- Restore: `out = shift_data >> shift_info` (logical, zero fill).
- `nzero=0`: output all zeros regardless of other fields.
- `shift_info > DATA_W-1` (192..255 at default): output all zeros, word counts as malformed.
- `nzero=1` and `shift_data[DATA_W-1]=0`: still shifted as specified, word counts as malformed.
- `nzero=0` with any other field nonzero: not malformed (don't-care fields).
- Shift decomposition at default `SH_W=8`: S1 by `shift_info[7:6]*64`, S2 by `shift_info[5:3]*8`, S3 by `shift_info[2:0]`. Remaining shift bits and a zero/force-zero flag travel with the data.
- `err_cnt` increments by 1 when a malformed word is accepted (`tvalid & tready` on input); saturates at `2^ERR_W-1`.

## Timing
- Reset values: `fixp_out_stream.tvalid=0`, `fixp_out_stream.tdata=0`, `err_cnt=0`, all stage valids 0.
- Latency: exactly 3 cycles from input handshake to output `tvalid` when downstream never stalls.
- Throughput: 1 word/cycle with `fixp_out_stream.tready=1`.
- Global enable `en = ~out_valid | fixp_out_stream.tready`. All stages advance together on `en`. `fixp_in_stream.tready = en` (combinational from downstream ready; bubbles are not collapsed).
- Output `tdata` holds stable while `tvalid=1 & tready=0`.
- No word is dropped or duplicated under any `tvalid`/`tready` pattern. Order is preserved.
- Input `tvalid=1` while `en=0`: no acceptance, and `err_cnt` does not change.
- Asynchronous reset mid-stream: all in-flight words are discarded. Output `tvalid` goes to 0 immediately.
- `err_cnt` updates on the cycle after the accepting handshake.

## Structure
- Package `fixp_pkg`:
  - `clogb2` function
  - `DATA_W` default
  - field offset constants `NZ_POS=0`, `SH_POS=1`, `DATA_POS=1+SH_W`
  - the normalized-word struct typedef
  - shared with `first_bit_checker`
- Sub-module `first_bit_restorer_stage`:
  - one enable-gated register stage
  - shifts by `sel*STEP`, where `STEP` and the select width are parameters
  - forwards valid, the remaining shift bits and the zero flag
  - instantiated 3 times
- Top holds the enable logic, the malformed-word detection and `err_cnt`.

## Test plan
- Sweep `s=0..191`: input `{1<<(191), s, 1}`, `tready=1` -> output `1<<(191-s)` three cycles later, one per cycle, `err_cnt=0`.
- `nzero=0`, `shift_info=5`, `shift_data=all ones` -> output 0, `err_cnt` unchanged. Then `nzero=1`, `shift_info=200` -> output 0, `err_cnt=1`.
- `nzero=1`, `shift_info=4`, `shift_data=192'h0…0F0` (MSB clear) -> output `192'h0…00F`, `err_cnt` increments to 1.
- Random `fixp_out_stream.tready` (50%) over 1000 random valid normalized words -> output sequence equals the reference model in order, no drops or duplicates, tdata stable during stalls.
- Assert `rstn=0` with 3 words in flight -> `tvalid` drops immediately, `err_cnt=0`. After release, the first new word emerges after 3 cycles.
- Force `err_cnt` near saturation (`ERR_W=2`): feed 5 malformed words -> `err_cnt` reaches 3 and holds.

Source files
------------

// File: rtl/fixp_pkg.sv
// Shared definitions for the normalized fixed-point word format used by
// first_bit_checker (normalize) and first_bit_restorer (denormalize).
package fixp_pkg;

  // Number of bits needed to represent value (0 for value 0).
  function automatic int clogb2(input int value);
    int v;
    int n;
    v = value;
    n = 0;
    while (v > 0) begin
      n = n + 1;
      v = v >> 1;
    end
    return n;
  endfunction

  localparam int DATA_W_DEF = 192;
  localparam int SH_W_DEF   = clogb2(DATA_W_DEF - 1);

  localparam int NZ_POS   = 0;
  localparam int SH_POS   = 1;
  localparam int DATA_POS = 1 + SH_W_DEF;

  // Packed MSB-first so it maps directly onto the stream tdata layout.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] shift_data;
    logic [SH_W_DEF-1:0]   shift_info;
    logic                  nzero;
  } norm_word_t;

endpackage

// File: rtl/first_bit_restorer_stage.sv
// One enable-gated pipeline stage of the restoring barrel shifter: shifts
// right by sel*STEP, where sel is a field of the carried shift count.
module first_bit_restorer_stage
  import fixp_pkg::*;
#(
  parameter int DATA_W  = 192,
  parameter int SH_W    = 8,
  parameter int SEL_LSB = 0,
  parameter int SEL_W   = 3,
  parameter int STEP    = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic              zero_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [SH_W-1:0]   sh_i,
  output logic              valid_o,
  output logic              zero_o,
  output logic [DATA_W-1:0] data_o,
  output logic [SH_W-1:0]   sh_o
);

  logic [SEL_W-1:0]  sel;
  logic [31:0]       amt;
  logic [DATA_W-1:0] data_d;
  logic              valid_q;
  logic              zero_q;
  logic [DATA_W-1:0] data_q;
  logic [SH_W-1:0]   sh_q;

  assign sel    = sh_i[SEL_LSB +: SEL_W];
  assign amt    = 32'(sel) * 32'(STEP);
  // A forced-zero word is cleared here so later stages only shift zeros.
  assign data_d = zero_i ? '0 : (data_i >> amt);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
      data_q  <= '0;
      sh_q    <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      zero_q  <= zero_i;
      data_q  <= data_d;
      sh_q    <= sh_i;
    end
  end

  assign valid_o = valid_q;
  assign zero_o  = zero_q;
  assign data_o  = data_q;
  assign sh_o    = sh_q;

endmodule

// File: rtl/first_bit_restorer.sv
// Rebuilds the original value from a normalized {shift_data, shift_info,
// nzero} word through a 3-stage right barrel shifter with backpressure.
module first_bit_restorer
  import fixp_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int SH_W   = clogb2(DATA_W - 1),
  parameter  int ERR_W  = 16,
  localparam int TD_W   = DATA_W + SH_W + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fixp_in_stream_tvalid,
  output logic              fixp_in_stream_tready,
  input  logic [TD_W-1:0]   fixp_in_stream_tdata,
  output logic              fixp_out_stream_tvalid,
  input  logic              fixp_out_stream_tready,
  output logic [DATA_W-1:0] fixp_out_stream_tdata,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int D_POS = SH_POS + SH_W;

  logic              en;
  logic              accept;
  logic              in_nz;
  logic [SH_W-1:0]   in_sh;
  logic [DATA_W-1:0] in_data;
  logic              sh_oob;
  logic              force_zero;
  logic              malformed;
  logic [ERR_W-1:0]  err_q;
  logic [ERR_W-1:0]  err_d;

  logic              v1, v2, v3;
  logic              z1, z2, z3;
  logic [DATA_W-1:0] d1, d2, d3;
  logic [SH_W-1:0]   s1, s2, s3;
  logic              unused_tail;

  assign in_nz   = fixp_in_stream_tdata[NZ_POS];
  assign in_sh   = fixp_in_stream_tdata[SH_POS +: SH_W];
  assign in_data = fixp_in_stream_tdata[D_POS +: DATA_W];

  assign sh_oob     = 32'(in_sh) > 32'(DATA_W - 1);
  assign force_zero = ~in_nz | sh_oob;
  assign malformed  = in_nz & (sh_oob | ~in_data[DATA_W-1]);

  // Valid/ready: a word moves on a rising edge where tvalid & tready; the
  // whole pipe advances together on en, so upstream ready is just en and
  // bubbles stay in place. Output tdata is held while tvalid & ~tready.
  assign en                    = ~v3 | fixp_out_stream_tready;
  assign fixp_in_stream_tready = en;
  assign accept                = fixp_in_stream_tvalid & en;

  first_bit_restorer_stage #(
    .DATA_W(DATA_W), .SH_W(SH_W), .SEL_LSB(6), .SEL_W(SH_W - 6), .STEP(64)
  ) u_s1 (
    .clk(clk), .rstn(rstn), .en_i(en),
    .valid_i(fixp_in_stream_tvalid), .zero_i(force_zero), .data_i(in_data), .sh_i(in_sh),
    .valid_o(v1), .zero_o(z1), .data_o(d1), .sh_o(s1)
  );

  first_bit_restorer_stage #(
    .DATA_W(DATA_W), .SH_W(SH_W), .SEL_LSB(3), .SEL_W(3), .STEP(8)
  ) u_s2 (
    .clk(clk), .rstn(rstn), .en_i(en),
    .valid_i(v1), .zero_i(z1), .data_i(d1), .sh_i(s1),
    .valid_o(v2), .zero_o(z2), .data_o(d2), .sh_o(s2)
  );

  first_bit_restorer_stage #(
    .DATA_W(DATA_W), .SH_W(SH_W), .SEL_LSB(0), .SEL_W(3), .STEP(1)
  ) u_s3 (
    .clk(clk), .rstn(rstn), .en_i(en),
    .valid_i(v2), .zero_i(z2), .data_i(d2), .sh_i(s2),
    .valid_o(v3), .zero_o(z3), .data_o(d3), .sh_o(s3)
  );

  assign fixp_out_stream_tvalid = v3;
  assign fixp_out_stream_tdata  = d3;
  assign unused_tail            = ^{s3, z3};

  always_comb begin
    err_d = err_q;
    if (accept && malformed && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;

endmodule

// File: tb/tb_first_bit_restorer.sv
// Bench for first_bit_restorer: vector table, shift sweep, randomized
// backpressure against a reference model, reset and saturation corners.
module tb_first_bit_restorer;

  localparam int DW  = 192;
  localparam int SW  = 8;
  localparam int TDW = DW + SW + 1;

  logic           clk = 1'b0;
  logic           rstn;
  logic           in_tvalid, in_tready;
  logic [TDW-1:0] in_tdata;
  logic           out_tvalid, out_tready;
  logic [DW-1:0]  out_tdata;
  logic [15:0]    err_cnt;

  logic           s_in_tvalid, s_in_tready;
  logic [TDW-1:0] s_in_tdata;
  logic           s_out_tvalid, s_out_tready;
  logic [DW-1:0]  s_out_tdata;
  logic [1:0]     s_err_cnt;

  first_bit_restorer dut (
    .clk(clk), .rstn(rstn),
    .fixp_in_stream_tvalid(in_tvalid), .fixp_in_stream_tready(in_tready),
    .fixp_in_stream_tdata(in_tdata),
    .fixp_out_stream_tvalid(out_tvalid), .fixp_out_stream_tready(out_tready),
    .fixp_out_stream_tdata(out_tdata), .err_cnt(err_cnt)
  );

  first_bit_restorer #(.ERR_W(2)) dut_sat (
    .clk(clk), .rstn(rstn),
    .fixp_in_stream_tvalid(s_in_tvalid), .fixp_in_stream_tready(s_in_tready),
    .fixp_in_stream_tdata(s_in_tdata),
    .fixp_out_stream_tvalid(s_out_tvalid), .fixp_out_stream_tready(s_out_tready),
    .fixp_out_stream_tdata(s_out_tdata), .err_cnt(s_err_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  int            acc_q[$];
  int            m_err = 0;
  bit            lat_chk = 0;
  bit            rdy_rand = 0;
  logic          rdy_level = 1'b1;
  int            chk_cnt = 0;
  int            pass_cnt = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: logical right shift of the mantissa, zero for nzero=0 or out-of-range shift.
  function automatic logic [DW-1:0] ref_restore(input logic nz, input logic [SW-1:0] sh,
                                               input logic [DW-1:0] d);
    if (!nz || int'(sh) >= DW) return '0;
    return d >> sh;
  endfunction

  function automatic bit ref_malformed(input logic nz, input logic [SW-1:0] sh,
                                       input logic [DW-1:0] d);
    return nz && (int'(sh) >= DW || !d[DW-1]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic nz, input logic [SW-1:0] sh, input logic [DW-1:0] data,
                           input logic [DW-1:0] exp);
    int waited;
    bit acc;
    int acyc;
    waited = 0;
    acc = 0;
    acyc = 0;
    in_tdata  = {data, sh, nz};
    in_tvalid = 1'b1;
    while (!acc && waited < 1000) begin
      @(negedge clk);
      if (in_tready) begin
        acc  = 1;
        acyc = cyc;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) begin
      check("accept_timeout", DW'(0), DW'(1));
    end else begin
      exp_q.push_back(exp);
      acc_q.push_back(acyc);
      if (ref_malformed(nz, sh, data) && m_err < 65535) m_err++;
    end
  endtask

  task automatic idle(input int n);
    in_tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    in_tvalid = 1'b0;
    while (exp_q.size() > 0 && w < 2000) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain_no_drop", DW'(exp_q.size()), DW'(0));
  endtask

  // ---------------- ready generator ----------------
  initial begin
    out_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) out_tready = 1'($urandom_range(0, 1));
      else          out_tready = rdy_level;
    end
  end

  // ---------------- output monitor ----------------
  initial begin
    logic [DW-1:0] e;
    logic [DW-1:0] prev_data;
    bit            prev_stall;
    int            a;
    prev_stall = 0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", DW'(out_tvalid), DW'(1));
          check("stall_data", out_tdata, prev_data);
        end
        if (out_tvalid && out_tready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", DW'(1), DW'(0));
          end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("out_data", out_tdata, e);
            check("err_cnt", DW'(err_cnt), DW'(m_err));
            if (lat_chk) check("latency", DW'(cyc - a), DW'(3));
          end
        end
        prev_stall = out_tvalid && !out_tready;
        prev_data  = out_tdata;
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic          nz;
    logic [SW-1:0] sh;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
    logic [15:0]   exp_err;
  } vec_t;

  vec_t tv[11];
  logic [1:0] sat_exp[5];

  initial begin
    logic [DW-1:0] one;
    logic [DW-1:0] ones;
    logic [DW-1:0] a4;
    logic [DW-1:0] rd;
    logic [SW-1:0] rsh;
    logic          rnz;

    one  = 1;
    ones = '1;
    a4   = 192'hA;
    tv[0]  = '{1'b1, 8'd0,   one << 191,    one << 191, 16'd0};
    tv[1]  = '{1'b1, 8'd191, one << 191,    one,        16'd0};
    tv[2]  = '{1'b1, 8'd64,  ones,          ones >> 64, 16'd0};
    tv[3]  = '{1'b0, 8'd5,   ones,          '0,         16'd0};
    tv[4]  = '{1'b1, 8'd200, one << 191,    '0,         16'd1};
    tv[5]  = '{1'b1, 8'd4,   192'hF0,       192'hF,     16'd2};
    tv[6]  = '{1'b0, 8'd255, '0,            '0,         16'd2};
    tv[7]  = '{1'b1, 8'd191, ones,          one,        16'd2};
    tv[8]  = '{1'b1, 8'd192, ones,          '0,         16'd3};
    tv[9]  = '{1'b1, 8'd73,  a4 << 188,     a4 << 115,  16'd3};
    tv[10] = '{1'b0, 8'd0,   '0,            '0,         16'd3};
    sat_exp[0] = 2'd1;
    sat_exp[1] = 2'd2;
    sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3;
    sat_exp[4] = 2'd3;

    rstn = 1'b0;
    in_tvalid = 1'b0;
    in_tdata = '0;
    s_in_tvalid = 1'b0;
    s_in_tdata = '0;
    s_out_tready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_tvalid", DW'(out_tvalid), DW'(0));
    check("reset_tdata", out_tdata, DW'(0));
    check("reset_err", DW'(err_cnt), DW'(0));
    check("reset_sat_err", DW'(s_err_cnt), DW'(0));
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("idle_tready", DW'(in_tready), DW'(1));

    // Table-driven vectors, each drained before the next.
    for (int i = 0; i < 11; i++) begin
      send_word(tv[i].nz, tv[i].sh, tv[i].data, tv[i].exp);
      drain();
      check("tbl_err", DW'(err_cnt), DW'(tv[i].exp_err));
    end

    // Back-to-back shift sweep with exact latency.
    lat_chk = 1;
    for (int s = 0; s < DW; s++) begin
      send_word(1'b1, 8'(s), one << 191, one << (191 - s));
    end
    drain();
    lat_chk = 0;
    check("sweep_err", DW'(err_cnt), DW'(3));

    // Random words under 50% downstream ready.
    rdy_rand = 1;
    for (int n = 0; n < 1000; n++) begin
      rd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 9) == 0) begin
        rnz = 1'($urandom_range(0, 1));
        rsh = 8'($urandom_range(0, 255));
      end else begin
        rnz = 1'b1;
        rsh = 8'($urandom_range(0, DW - 1));
        rd[DW-1] = 1'b1;
      end
      send_word(rnz, rsh, rd, ref_restore(rnz, rsh, rd));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    drain();
    rdy_rand = 0;
    idle(2);

    // Reset with three malformed words in flight.
    for (int i = 0; i < 3; i++) send_word(1'b1, 8'd200, one << 191, '0);
    in_tvalid = 1'b0;
    rstn = 1'b0;
    #1;
    check("rst_tvalid_drop", DW'(out_tvalid), DW'(0));
    check("rst_err_clear", DW'(err_cnt), DW'(0));
    exp_q.delete();
    acc_q.delete();
    m_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    lat_chk = 1;
    send_word(1'b1, 8'd10, one << 191, one << 181);
    drain();
    lat_chk = 0;

    // Held output: a waiting input word must not be taken nor counted.
    rdy_level = 1'b0;
    send_word(1'b1, 8'd0, one << 191, one << 191);
    idle(4);
    in_tdata  = {192'hF0, 8'd4, 1'b1};
    in_tvalid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("stall_in_tready", DW'(in_tready), DW'(0));
    check("stall_err_hold", DW'(err_cnt), DW'(m_err));
    in_tvalid = 1'b0;
    rdy_level = 1'b1;
    drain();

    // Saturating counter on the 2-bit instance.
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) s_in_tdata = {one << 191, 8'd200, 1'b1};
      else            s_in_tdata = {192'hF0, 8'd4, 1'b1};
      s_in_tvalid = 1'b1;
      @(posedge clk);
      #1;
      check("sat_err", DW'(s_err_cnt), DW'(sat_exp[i]));
    end
    s_in_tvalid = 1'b0;
    idle(5);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
